// File: rtl/lam_unit.sv
// Load/store access unit: one memory transaction per request, stalling the pipeline until done.
// Optional macro LAM_MISALIGN_TRAP_EN traps misaligned halfword/word accesses instead of issuing them.
module lam_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  lam_control,
  input  logic        lam_new,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_sel,
  output logic [31:0] wb_data,
  output logic        misalign_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StWb} state_e;
  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  // Store encodings 100/101 are not defined, so they fall back to word access.
  function automatic size_e access_size(input logic is_store, input logic [2:0] f3);
    case (f3)
      3'b000:  access_size = SzByte;
      3'b001:  access_size = SzHalf;
      3'b100:  access_size = is_store ? SzWord : SzByte;
      3'b101:  access_size = is_store ? SzWord : SzHalf;
      default: access_size = SzWord;
    endcase
  endfunction

  state_e      state_q;
  size_e       size_q;
  logic        store_q;
  logic        uns_q;
  logic [4:0]  rd_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        wb_en_q;
  logic [31:0] wb_data_q;
  logic        err_q;

  size_e       acc_size;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic        misalign;
  logic        accept;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;

  assign accept = lam_new || lam_control[8];

  always_comb begin
    acc_size = access_size(lam_control[8], lam_control[7:5]);
    case (acc_size)
      SzByte: begin
        be_n    = 4'b0001 << alu_out[1:0];
        wdata_n = {4{store_data[7:0]}};
      end
      SzHalf: begin
        be_n    = 4'b0011 << {alu_out[1], 1'b0};
        wdata_n = {2{store_data[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = store_data;
      end
    endcase
`ifdef LAM_MISALIGN_TRAP_EN
    misalign = ((acc_size == SzHalf) && alu_out[0]) ||
               ((acc_size == SzWord) && (alu_out[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
  end

  always_comb begin
    byte_lane = 8'(mem_rdata >> {addr_q[1:0], 3'b000});
    half_lane = 16'(mem_rdata >> {addr_q[1], 4'b0000});
    case (size_q)
      SzByte:  load_data = {{24{byte_lane[7] & ~uns_q}}, byte_lane};
      SzHalf:  load_data = {{16{half_lane[15] & ~uns_q}}, half_lane};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      size_q    <= SzByte;
      store_q   <= 1'b0;
      uns_q     <= 1'b0;
      rd_q      <= 5'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      wb_en_q   <= 1'b0;
      wb_data_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      wb_en_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            size_q  <= acc_size;
            store_q <= lam_control[8];
            uns_q   <= lam_control[7];
            rd_q    <= lam_control[4:0];
            addr_q  <= alu_out;
            wdata_q <= wdata_n;
            be_q    <= be_n;
            // A trapped access spends its single stall cycle in StWb with wb_en held low.
            if (misalign) begin
              err_q   <= 1'b1;
              state_q <= StWb;
            end else begin
              state_q <= StReq;
            end
          end
        end
        StReq:  state_q <= StWait;
        StWait: begin
          if (mem_ready) begin
            if (store_q) begin
              state_q <= StIdle;
            end else begin
              wb_data_q <= load_data;
              wb_en_q   <= (rd_q != 5'd0);
              state_q   <= StWb;
            end
          end
        end
        StWb:    state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall        = (state_q != StIdle);
  assign mem_req      = (state_q == StReq) || (state_q == StWait);
  assign mem_we       = mem_req && store_q;
  assign mem_addr     = {addr_q[31:2], 2'b00};
  assign mem_be       = be_q;
  assign mem_wdata    = wdata_q;
  assign wb_en        = wb_en_q;
  assign wb_sel       = rd_q;
  assign wb_data      = wb_data_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_lam_unit.sv
// Bench for lam_unit: directed vector table, reset/ready corner sequences and a randomized run
// checked against an arithmetic reference model. Honours LAM_MISALIGN_TRAP_EN like the design.
module tb_lam_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  lam_control;
  logic        lam_new;
  logic [31:0] alu_out;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data;
  logic        misalign_err;

  lam_unit dut (
    .clk          (clk),
    .reset        (reset),
    .lam_control  (lam_control),
    .lam_new      (lam_new),
    .alu_out      (alu_out),
    .store_data   (store_data),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .stall        (stall),
    .wb_en        (wb_en),
    .wb_sel       (wb_sel),
    .wb_data      (wb_data),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Monitor: observed activity since the last clear
  int          stall_cnt, req_cnt, err_cnt, wb_cnt, wb_cyc;
  logic [31:0] wb_data_seen;
  logic [4:0]  wb_sel_seen;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (stall) stall_cnt++;
    if (mem_req) req_cnt++;
    if (misalign_err) err_cnt++;
    if (wb_en) begin
      wb_cnt++;
      wb_data_seen = wb_data;
      wb_sel_seen  = wb_sel;
      wb_cyc       = cyc;
    end
  end

  task automatic clear_mon();
    stall_cnt = 0; req_cnt = 0; err_cnt = 0; wb_cnt = 0; wb_cyc = -1;
    wb_data_seen = '0; wb_sel_seen = '0;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: access size in bytes, lane offset and data from plain arithmetic.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] rdata,
                       output logic [3:0] be, output logic [31:0] wd, output logic [31:0] wb,
                       output logic mis);
    int          sz, lane;
    logic [31:0] mask, v;
    if (f3 == 3'd0 || (!st && f3 == 3'd4)) sz = 1;
    else if (f3 == 3'd1 || (!st && f3 == 3'd5)) sz = 2;
    else sz = 4;
`ifdef LAM_MISALIGN_TRAP_EN
    mis = (sz == 2 && (addr % 2) != 0) || (sz == 4 && (addr % 4) != 0);
`else
    mis = 1'b0;
`endif
    if (sz == 1) lane = int'(addr % 4);
    else if (sz == 2) lane = int'((addr % 4) / 2) * 2;
    else lane = 0;
    be = 4'(((1 << sz) - 1) << lane);
    if (sz == 1) wd = {24'd0, sdata[7:0]} * 32'h0101_0101;
    else if (sz == 2) wd = {16'd0, sdata[15:0]} * 32'h0001_0001;
    else wd = sdata;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v = (rdata >> (8 * lane)) & mask;
    if (f3[2] == 1'b0 && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
    wb = v;
  endtask

  task automatic run_txn(input string nm, input logic st, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int waits, input logic [3:0] ebe,
                         input logic [31:0] ewd, input logic [31:0] ewb, input logic ewben,
                         input logic emis);
    int acc;
    @(negedge clk);
    clear_mon();
    lam_control = {st, f3, rd};
    lam_new     = !st;
    alu_out     = addr;
    store_data  = sdata;
    mem_ready   = 1'b0;
    acc         = cyc;
    @(negedge clk);
    // Inputs now change freely; the unit must use what it latched.
    lam_new     = 1'b0;
    lam_control = 9'd0;
    alu_out     = $urandom;
    store_data  = $urandom;
    if (!emis) begin
      check({nm, " mem_req"}, 32'(mem_req), 32'd1);
      check({nm, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
      check({nm, " mem_we"}, 32'(mem_we), 32'(st));
      if (st) begin
        check({nm, " mem_be"}, 32'(mem_be), 32'(ebe));
        check({nm, " mem_wdata"}, mem_wdata, ewd);
      end
      mem_ready = 1'b1;
      mem_rdata = $urandom;
      @(negedge clk);
      repeat (waits) begin
        mem_ready = 1'b0;
        @(negedge clk);
      end
      mem_ready = 1'b1;
      mem_rdata = rdata;
      @(negedge clk);
      mem_ready = 1'b0;
    end
    repeat (3) @(negedge clk);
    check({nm, " stall cycles"}, 32'(stall_cnt), emis ? 32'd1 : 32'(st ? waits + 2 : waits + 3));
    check({nm, " mem_req cycles"}, 32'(req_cnt), emis ? 32'd0 : 32'(waits + 2));
    check({nm, " misalign pulses"}, 32'(err_cnt), 32'(emis));
    check({nm, " wb_en pulses"}, 32'(wb_cnt), 32'(ewben));
    if (ewben) begin
      check({nm, " wb_data"}, wb_data_seen, ewb);
      check({nm, " wb_sel"}, 32'(wb_sel_seen), 32'(rd));
      check({nm, " latency"}, 32'(wb_cyc), 32'(acc + 3 + waits));
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, " stall"}, 32'(stall), 32'd0);
    check({nm, " mem_req"}, 32'(mem_req), 32'd0);
    check({nm, " mem_we"}, 32'(mem_we), 32'd0);
    check({nm, " mem_be"}, 32'(mem_be), 32'd0);
    check({nm, " mem_addr"}, mem_addr, 32'd0);
    check({nm, " mem_wdata"}, mem_wdata, 32'd0);
    check({nm, " wb_en"}, 32'(wb_en), 32'd0);
    check({nm, " wb_sel"}, 32'(wb_sel), 32'd0);
    check({nm, " wb_data"}, wb_data, 32'd0);
    check({nm, " misalign_err"}, 32'(misalign_err), 32'd0);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          waits;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] wb;
    logic        wben;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [3:0]  mbe;
    logic [31:0] mwd, mwb;
    logic        mmis;

    vecs[0] = '{1'b1, 3'b010, 5'd3,  32'h100, 32'hDEAD_BEEF, 32'h0, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 3'b000, 5'd5,  32'h103, 32'h0, 32'h80FF_0000, 0, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b1};
    vecs[2] = '{1'b0, 3'b101, 5'd7,  32'h102, 32'h0, 32'h8001_1234, 0, 4'h0, 32'h0, 32'h0000_8001, 1'b1};
    vecs[3] = '{1'b1, 3'b000, 5'd2,  32'h101, 32'h0000_00AB, 32'h0, 0, 4'b0010, 32'hABAB_ABAB, 32'h0, 1'b0};
    vecs[4] = '{1'b1, 3'b001, 5'd4,  32'h102, 32'h1234_CAFE, 32'h0, 2, 4'b1100, 32'hCAFE_CAFE, 32'h0, 1'b0};
    vecs[5] = '{1'b0, 3'b001, 5'd31, 32'h200, 32'h0, 32'h1234_F00D, 2, 4'h0, 32'h0, 32'hFFFF_F00D, 1'b1};
    vecs[6] = '{1'b0, 3'b010, 5'd1,  32'h7FC, 32'h0, 32'hCAFE_BABE, 1, 4'h0, 32'h0, 32'hCAFE_BABE, 1'b1};
    vecs[7] = '{1'b0, 3'b100, 5'd2,  32'h101, 32'h0, 32'h0000_9A00, 0, 4'h0, 32'h0, 32'h0000_009A, 1'b1};
    vecs[8] = '{1'b0, 3'b000, 5'd0,  32'h010, 32'h0, 32'hFFFF_FFFF, 0, 4'h0, 32'h0, 32'h0, 1'b0};
    vecs[9] = '{1'b0, 3'b111, 5'd4,  32'h300, 32'h0, 32'h1122_3344, 3, 4'h0, 32'h0, 32'h1122_3344, 1'b1};

    reset = 1'b1; lam_control = 9'd0; lam_new = 1'b0; alu_out = '0; store_data = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    clear_mon();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // mem_ready while idle must not start anything
    clear_mon();
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    check("idle ready stall", 32'(stall_cnt), 32'd0);
    check("idle ready wb_en", 32'(wb_cnt), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].st, vecs[i].f3, vecs[i].rd, vecs[i].addr,
              vecs[i].sdata, vecs[i].rdata, vecs[i].waits, vecs[i].be, vecs[i].wd, vecs[i].wb,
              vecs[i].wben, 1'b0);
    end

`ifdef LAM_MISALIGN_TRAP_EN
    run_txn("trap lw", 1'b0, 3'b010, 5'd6, 32'h102, 32'h0, 32'hAABB_CCDD, 0, 4'h0, 32'h0,
            32'h0, 1'b0, 1'b1);
    run_txn("trap sh", 1'b1, 3'b001, 5'd6, 32'h103, 32'h5555, 32'h0, 0, 4'h0, 32'h0,
            32'h0, 1'b0, 1'b1);
`else
    run_txn("lw lane0", 1'b0, 3'b010, 5'd6, 32'h102, 32'h0, 32'hAABB_CCDD, 0, 4'h0, 32'h0,
            32'hAABB_CCDD, 1'b1, 1'b0);
    run_txn("lhu hi", 1'b0, 3'b101, 5'd8, 32'h103, 32'h0, 32'h1234_5678, 1, 4'h0, 32'h0,
            32'h0000_1234, 1'b1, 1'b0);
`endif

    // Reset during WAIT drops the access; a late ready afterwards is ignored
    @(negedge clk);
    lam_control = {1'b0, 3'b010, 5'd9}; lam_new = 1'b1; alu_out = 32'h40;
    @(negedge clk);
    lam_new = 1'b0; lam_control = 9'd0;
    @(negedge clk);
    check("rstwait mem_req before", 32'(mem_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("rstwait");
    clear_mon();
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    check("rstwait late ready wb_en", 32'(wb_cnt), 32'd0);
    check("rstwait late ready stall", 32'(stall_cnt), 32'd0);

    // Reset wins over a simultaneous request
    clear_mon();
    lam_control = {1'b0, 3'b010, 5'd3}; lam_new = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; lam_new = 1'b0; lam_control = 9'd0;
    repeat (2) @(negedge clk);
    check("rst prio stall", 32'(stall_cnt), 32'd0);
    check("rst prio mem_req", 32'(req_cnt), 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic        st;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] addr, sdata, rdata;
      int          waits;
      st    = 1'($urandom);
      f3    = 3'($urandom);
      rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      addr  = $urandom;
      sdata = $urandom;
      rdata = $urandom;
      waits = $urandom_range(0, 3);
      model(st, f3, addr, sdata, rdata, mbe, mwd, mwb, mmis);
      run_txn($sformatf("rnd%0d", i), st, f3, rd, addr, sdata, rdata, waits, mbe, mwd, mwb,
              !st && rd != 5'd0 && !mmis, mmis);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lam_unit.md
LAM_UNIT -- requirements
Module: lam_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: lam_control  input  9  {store flag, funct3[2:0], reg index[4:0]} from the decoder; reg index is rs2 for stores and rd for loads.
REQ-004 SHALL have port: lam_new  input  1  load request strobe from the decoder.
REQ-005 SHALL have port: alu_out  input  32  effective address (rs1 + imm) from the ALU.
REQ-006 SHALL have port: store_data  input  32  rs2 value for stores.
REQ-007 SHALL have ports: mem_req out 1; mem_we out 1; mem_addr out 32 word-aligned; mem_wdata out 32; mem_be out 4; mem_ready in 1; mem_rdata in 32.
REQ-008 SHALL have ports: stall out 1 (pipeline hold); wb_en out 1; wb_sel out 5; wb_data out 32; misalign_err out 1.

Function
REQ-009 SHALL implement FSM states IDLE, REQ, WAIT, WB.
REQ-010 In IDLE, SHALL accept a load when lam_new=1, or a store when lam_control[8]=1; it SHALL latch alu_out, store_data and lam_control on that edge and go to REQ.
REQ-011 Any request presented outside IDLE SHALL be ignored; upstream holds it while stall=1.
REQ-012 stall SHALL be 1 in every state except IDLE.
REQ-013 In REQ and WAIT, mem_req SHALL be 1, with mem_addr = {addr[31:2],2'b00} and mem_we = store flag; REQ goes to WAIT unconditionally.
REQ-014 In WAIT, mem_req SHALL stay 1 until mem_ready=1 is sampled; a store then returns to IDLE; a load registers mem_rdata and goes to WB.
REQ-015 In WB, wb_en SHALL be 1 for exactly one cycle, with wb_sel = rd, and the FSM SHALL then return to IDLE.
REQ-016 A load with rd=0 SHALL still perform the memory access, but wb_en SHALL stay 0.
REQ-017 mem_be SHALL be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
REQ-018 mem_wdata SHALL be: SB byte replicated 4x; SH halfword replicated 2x; SW the full word.
REQ-019 Load data SHALL be taken from the lane addressed by addr[1:0]: LB 000 and LH 001 sign-extend; LBU 100 and LHU 101 zero-extend; LW 010 passes through.
REQ-020 Any other funct3 SHALL be treated as a word access.
REQ-021 Total latency from accept to wb_en SHALL be 3 cycles plus the number of wait cycles before mem_ready.
REQ-022 mem_ready asserted while in IDLE, REQ or WB SHALL be ignored.

Reset
REQ-023 reset SHALL force IDLE within one cycle, including mid-transaction; the pending access is dropped and mem_req falls on the next edge.
REQ-024 On reset, all outputs SHALL be 0: stall, mem_req, mem_we, mem_be, mem_addr, mem_wdata, wb_en, wb_sel, wb_data and misalign_err.
REQ-025 reset SHALL take priority over a simultaneous request.

Configuration
REQ-026 Macro LAM_MISALIGN_TRAP_EN, when defined, SHALL check accepted accesses for misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-027 With LAM_MISALIGN_TRAP_EN defined, a misaligned access SHALL skip REQ/WAIT, issue no mem_req, pulse misalign_err for one cycle, suppress wb_en, and return to IDLE.
REQ-028 Without LAM_MISALIGN_TRAP_EN, misalign_err SHALL be tied to 0 and the offending low address bits ignored: H uses addr[1], W uses lane 0.

Verification
REQ-029 Store SW: alu_out=0x100, store_data=0xDEADBEEF, mem_ready on the 2nd WAIT cycle -> mem_we=1, mem_be=1111, mem_addr=0x100, stall for 3 cycles.
REQ-030 Load LB: alu_out=0x103, mem_rdata=0x80FF_0000 (byte 3 = 0x80), rd=5, ready immediately -> wb_en pulse, wb_sel=5, wb_data=0xFFFFFF80.
REQ-031 Load LHU: alu_out=0x102, mem_rdata=0x8001_1234 -> wb_data=0x00008001; SB at addr 0x101 with data 0xAB -> mem_be=0010, mem_wdata=0xABABABAB.
REQ-032 Load with rd=0 -> mem_req observed, wb_en never asserted.
REQ-033 reset asserted in WAIT -> next cycle: IDLE, mem_req=0, stall=0; a late mem_ready is ignored.
REQ-034 LAM_MISALIGN_TRAP_EN defined, LW at 0x102 -> misalign_err=1 for one cycle, no mem_req, no wb_en.
